led_pio_sequencer: RTL and testbench

Autonomous LED pattern sequencer for the board's 8-bit LED PIO. The CPU loads a short pattern table, dwell period and mode through a small Avalon-MM slave CSR port. The block then acts as an Avalon-MM master and writes successive patterns to the LED PIO data register (offset 0), either once or looping. This keeps blink and heartbeat patterns running without CPU involvement.

---
 rtl/led_pio_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_led_pio_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_sequencer.sv
// Autonomous LED pattern sequencer: CSR slave holds a pattern table, dwell and mode,
// and an Avalon-MM master replays the table into the LED PIO data register.
module led_pio_sequencer #(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WAIT} state_t;

  localparam logic [4:0] CSR_CTRL   = 5'd0;
  localparam logic [4:0] CSR_PERIOD = 5'd1;
  localparam logic [4:0] CSR_LENGTH = 5'd2;
  localparam logic [4:0] CSR_STATUS = 5'd3;
  localparam logic [4:0] DEPTH_L    = 5'(DEPTH);

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic                loop_q, loop_d;
  logic                done_q, done_d;
  logic                m_write_q, m_write_d;
  logic [7:0]          data_q, data_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [4:0]          length_q, length_d;
  logic [3:0]          index_q, index_d;
  logic [7:0]          pattern_q [16];
  logic [7:0]          pattern_d [16];

  logic                csr_wr;
  logic                start;
  logic                last_entry;
  logic [4:0]          wr_len;
  logic [PERIOD_W-1:0] eff_period;
  logic [3:0]          next_index;
  logic                unused_wdata;

  assign csr_wr       = s_chipselect & ~s_write_n;
  assign wr_len       = s_writedata[4:0];
  assign eff_period   = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign next_index   = index_q + 4'd1;
  assign last_entry   = ({1'b0, index_q} + 5'd1) >= length_q;
  assign start        = csr_wr && (s_address == CSR_CTRL) && s_writedata[0] &&
                        !run_q && (state_q == ST_IDLE);
  assign unused_wdata = ^s_writedata;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    loop_d    = loop_q;
    done_d    = done_q;
    m_write_d = m_write_q;
    data_d    = data_q;
    period_d  = period_q;
    length_d  = length_q;
    index_d   = index_q;
    count_d   = count_q;
    pattern_d = pattern_q;

    if (csr_wr) begin
      case (s_address)
        CSR_CTRL: begin
          run_d  = s_writedata[0];
          loop_d = s_writedata[1];
        end
        CSR_PERIOD: period_d = s_writedata[PERIOD_W-1:0];
        CSR_LENGTH: begin
          if (wr_len == 5'd0)
            length_d = 5'd1;
          else if (wr_len > DEPTH_L)
            length_d = DEPTH_L;
          else
            length_d = wr_len;
        end
        default: begin
          if (s_address[4] && ({1'b0, s_address[3:0]} < DEPTH_L))
            pattern_d[s_address[3:0]] = s_writedata[7:0];
        end
      endcase
    end

    // Entries beyond DEPTH do not exist; hold them at zero so they fold away.
    for (int i = DEPTH; i < 16; i++)
      pattern_d[i] = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WRITE;
          index_d   = 4'd0;
          done_d    = 1'b0;
          m_write_d = 1'b1;
          data_d    = pattern_q[4'd0];
        end
      end
      ST_WRITE: begin
        // An issued write is never aborted; a stop only takes effect once it is accepted.
        if (!m_waitrequest) begin
          m_write_d = 1'b0;
          if (run_d) begin
            state_d = ST_WAIT;
            count_d = eff_period;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (!run_d) begin
          state_d = ST_IDLE;
        end else if (count_q == PERIOD_W'(1)) begin
          if (!last_entry) begin
            state_d   = ST_WRITE;
            index_d   = next_index;
            m_write_d = 1'b1;
            data_d    = pattern_q[next_index];
          end else if (loop_q) begin
            state_d   = ST_WRITE;
            index_d   = 4'd0;
            m_write_d = 1'b1;
            data_d    = pattern_q[4'd0];
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            run_d   = 1'b0;
          end
        end else begin
          count_d = count_q - PERIOD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      loop_q    <= 1'b0;
      done_q    <= 1'b0;
      m_write_q <= 1'b0;
      data_q    <= 8'h00;
      period_q  <= '0;
      count_q   <= '0;
      length_q  <= 5'd1;
      index_q   <= 4'd0;
      for (int i = 0; i < 16; i++)
        pattern_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      loop_q    <= loop_d;
      done_q    <= done_d;
      m_write_q <= m_write_d;
      data_q    <= data_d;
      period_q  <= period_d;
      count_q   <= count_d;
      length_q  <= length_d;
      index_q   <= index_d;
      pattern_q <= pattern_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign m_address   = 2'b00;
  assign m_write     = m_write_q;
  assign m_writedata = {24'h000000, data_q};

  always_comb begin
    s_readdata = 32'h0;
    case (s_address)
      CSR_CTRL:   s_readdata = {30'h0, loop_q, run_q};
      CSR_PERIOD: s_readdata = 32'(period_q);
      CSR_LENGTH: s_readdata = {27'h0, length_q};
      CSR_STATUS: s_readdata = {20'h0, index_q, 6'h0, done_q, busy};
      default: begin
        if (s_address[4] && ({1'b0, s_address[3:0]} < DEPTH_L))
          s_readdata = {24'h0, pattern_q[s_address[3:0]]};
      end
    endcase
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Scoreboard bench for led_pio_sequencer: stimulus pushes expected PIO writes,
// a negedge monitor pops and checks data and dwell spacing on every accepted write.
module tb_led_pio_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  s_address = '0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        busy;

  led_pio_sequencer #(.DEPTH(DEPTH), .PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         exp_gap = 2;
  bit         first_write = 1'b1;
  int         acc_count = 0;
  int         cyc = 0;
  bit         stall_en = 1'b0;
  bit         force_stall = 1'b0;

  // Reference model of the CSR-visible configuration.
  logic [7:0] mdl_pat [16];
  int         mdl_len = 1;
  int         mdl_period = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl_pat[i] = 8'h00;
    mdl_len = 1;
    mdl_period = 0;
  endtask

  // Callers sit on a negedge; each CSR access consumes one clock.
  task automatic csr_write(input logic [4:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic csr_read(input logic [4:0] a, output logic [31:0] d);
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b1;
    #1 d = s_readdata;
    s_chipselect = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    check(name, d, exp);
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    int l;
    if (a == 5'd1) mdl_period = int'(d[23:0]);
    if (a == 5'd2) begin
      l = int'(d[4:0]);
      mdl_len = (l == 0) ? 1 : ((l > DEPTH) ? DEPTH : l);
    end
    if (a >= 5'd16 && int'(a) < 16 + DEPTH) mdl_pat[a - 5'd16] = d[7:0];
    csr_write(a, d);
  endtask

  task automatic arm_expectations();
    exp_gap = ((mdl_period == 0) ? 1 : mdl_period) + 1;
    first_write = 1'b1;
    acc_count = 0;
  endtask

  task automatic push_sequence(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mdl_pat[i % mdl_len]);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'h0, busy}, 32'h0);
  endtask

  // Fabric stall generator, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_waitrequest = force_stall ? 1'b1 : (stall_en ? ($urandom_range(0, 1) == 1) : 1'b0);
    end
  end

  // Monitor: checks every cycle a write is presented and every accept.
  initial begin
    bit prev_mw = 1'b0;
    int last_acc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_mw = 1'b0;
      end else begin
        if (m_write) begin
          if (!prev_mw) begin
            if (exp_q.size() == 0) check("unexpected_write", 32'h1, 32'h0);
            else if (!first_write) check("dwell_gap", 32'(cyc - last_acc), 32'(exp_gap));
            first_write = 1'b0;
          end
          if (exp_q.size() != 0) begin
            check("m_writedata", m_writedata, {24'h0, exp_q[0]});
            if (!m_waitrequest) begin
              void'(exp_q.pop_front());
              last_acc = cyc;
              acc_count++;
            end
          end
        end
        prev_mw = m_write;
      end
    end
  end

  initial begin
    int k;
    int len;
    logic [7:0] p0, p2;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset values");
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_mwrite", {31'h0, m_write}, 32'h0);
    check("m_address", {30'h0, m_address}, 32'h0);
    read_check("reset_ctrl", 5'd0, 32'h0);
    read_check("reset_period", 5'd1, 32'h0);
    read_check("reset_length", 5'd2, 32'h1);
    read_check("reset_status", 5'd3, 32'h0);
    read_check("reset_pat0", 5'd16, 32'h0);

    $display("[TB] reset during stalled write");
    model_write(5'd16, 32'h5A);
    arm_expectations();
    exp_q.push_back(8'h5A);
    force_stall = 1'b1;
    csr_write(5'd0, 32'h1);
    check("start_mwrite", {31'h0, m_write}, 32'h1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_mwrite_drop", {31'h0, m_write}, 32'h0);
    check("async_busy_drop", {31'h0, busy}, 32'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    force_stall = 1'b0;
    repeat (20) @(negedge clk);
    read_check("post_reset_ctrl", 5'd0, 32'h0);
    read_check("post_reset_status", 5'd3, 32'h0);
    read_check("post_reset_pat0", 5'd16, 32'h0);

    $display("[TB] one-shot sequence");
    model_write(5'd16, 32'h01);
    model_write(5'd17, 32'h02);
    model_write(5'd18, 32'h04);
    model_write(5'd2, 32'd3);
    model_write(5'd1, 32'd5);
    arm_expectations();
    push_sequence(mdl_len);
    csr_write(5'd0, 32'h1);
    wait_idle("oneshot_idle", 300);
    read_check("oneshot_status", 5'd3, 32'h202);
    read_check("oneshot_ctrl", 5'd0, 32'h0);
    check("oneshot_count", 32'(acc_count), 32'd3);
    check("oneshot_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] loop with stalls, stop during WAIT");
    model_write(5'd2, 32'd2);
    model_write(5'd1, 32'd3);
    arm_expectations();
    push_sequence(60);
    stall_en = 1'b1;
    csr_write(5'd0, 32'h3);
    k = 0;
    while (!(acc_count >= 8 && !m_write && busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("loop_progress", {31'h0, acc_count >= 8}, 32'h1);
    csr_write(5'd0, 32'h2);
    exp_q.delete();
    stall_en = 1'b0;
    repeat (15) @(negedge clk);
    read_check("stop_wait_status", 5'd3, {20'h0, 4'(((acc_count - 1) % 2)), 8'h00});
    read_check("stop_wait_ctrl", 5'd0, 32'h2);

    $display("[TB] stop during stalled write");
    model_write(5'd1, 32'd2);
    arm_expectations();
    push_sequence(4);
    force_stall = 1'b1;
    csr_write(5'd0, 32'h3);
    check("stall_mwrite", {31'h0, m_write}, 32'h1);
    csr_write(5'd0, 32'h0);
    repeat (3) @(negedge clk);
    check("stall_still_busy", {31'h0, busy}, 32'h1);
    force_stall = 1'b0;
    wait_idle("stop_write_idle", 50);
    check("stop_write_count", 32'(acc_count), 32'd1);
    exp_q.delete();
    repeat (10) @(negedge clk);
    read_check("stop_write_status", 5'd3, 32'h0);

    $display("[TB] clamps and unmapped addresses");
    model_write(5'd2, 32'd0);
    read_check("len_clamp_low", 5'd2, 32'd1);
    model_write(5'd2, 32'd31);
    read_check("len_clamp_high", 5'd2, 32'(DEPTH));
    csr_write(5'd7, 32'hDEADBEEF);
    read_check("unmapped_7", 5'd7, 32'h0);
    read_check("unmapped_5", 5'd5, 32'h0);
    read_check("unmapped_pat", 5'(16 + DEPTH), 32'h0);
    model_write(5'd16, 32'h11);
    model_write(5'd17, 32'h22);
    model_write(5'd18, 32'h33);
    model_write(5'd2, 32'd3);
    model_write(5'd1, 32'd0);
    arm_expectations();
    push_sequence(mdl_len);
    csr_write(5'd0, 32'h1);
    wait_idle("period0_idle", 100);
    check("period0_count", 32'(acc_count), 32'd3);

    $display("[TB] live pattern update and RUN rewrite");
    p0 = 8'($urandom);
    p2 = 8'($urandom);
    model_write(5'd16, {24'h0, p0});
    model_write(5'd17, 32'h55);
    model_write(5'd18, {24'h0, p2});
    model_write(5'd1, 32'd6);
    arm_expectations();
    exp_q.push_back(p0);
    exp_q.push_back(8'hAA);
    exp_q.push_back(p2);
    csr_write(5'd0, 32'h1);
    k = 0;
    while (!(acc_count >= 1 && !m_write) && k < 100) begin
      @(negedge clk);
      k++;
    end
    model_write(5'd17, 32'hAA);
    csr_write(5'd0, 32'h1);
    wait_idle("live_idle", 200);
    check("live_count", 32'(acc_count), 32'd3);
    read_check("live_status", 5'd3, 32'h202);

    $display("[TB] randomized one-shot runs");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) model_write(5'(16 + i), {24'h0, 8'($urandom)});
      model_write(5'd2, 32'($urandom_range(0, 31)));
      model_write(5'd1, 32'($urandom_range(0, 4)));
      len = mdl_len;
      stall_en = ($urandom_range(0, 1) == 1);
      arm_expectations();
      push_sequence(mdl_len);
      csr_write(5'd0, 32'h1);
      wait_idle("rand_idle", 3000);
      stall_en = 1'b0;
      check("rand_count", 32'(acc_count), 32'(len));
      read_check("rand_status", 5'd3, {20'h0, 4'(len - 1), 8'h02});
      exp_q.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
